// File: rtl/fpu_pkg.sv
// Shared types, op encodings and op-class helpers for the FPU issue/writeback stage.
package fpu_pkg;

   localparam int NREGS  = 32;
   localparam int DATA_W = 32;
   localparam int AW     = $clog2(NREGS);

   typedef logic [AW-1:0]     reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;
   typedef logic [3:0]        fpu_op_t;

   localparam fpu_op_t FPU_MOV1 = 4'b0000;
   localparam fpu_op_t FPU_ADD  = 4'b0001;
   localparam fpu_op_t FPU_SUB  = 4'b0010;
   localparam fpu_op_t FPU_EQ   = 4'b0011;
   localparam fpu_op_t FPU_LT   = 4'b0100;
   localparam fpu_op_t FPU_LE   = 4'b0101;
   localparam fpu_op_t FPU_GE   = 4'b0110;
   localparam fpu_op_t FPU_GT   = 4'b0111;
   localparam fpu_op_t FPU_MOV2 = 4'b1000;

   function automatic logic is_wb_op(input fpu_op_t op);
      return (op == FPU_MOV1) || (op == FPU_ADD) || (op == FPU_SUB) || (op == FPU_MOV2);
   endfunction

   function automatic logic is_cmp_op(input fpu_op_t op);
      return (op >= FPU_EQ) && (op <= FPU_GT);
   endfunction

endpackage

// File: rtl/fpu_issue_wb_if.sv
// Bundle of issue, ext-write, FPU, writeback, flag and debug signals of the stage.
interface fpu_issue_wb_if;
   import fpu_pkg::*;

   logic     in_valid;
   logic     in_ready;
   fpu_op_t  in_op;
   reg_idx_t in_fs;
   reg_idx_t in_ft;
   reg_idx_t in_fd;
   logic     ext_we;
   reg_idx_t ext_addr;
   word_t    ext_wdata;
   word_t    fpu_src1;
   word_t    fpu_src2;
   fpu_op_t  fpu_control;
   word_t    fpu_result;
   logic     fpu_status_flag;
   logic     fpu_exception;
   logic     fpu_overflow_flag;
   logic     fpu_underflow_flag;
   logic     wb_valid;
   reg_idx_t wb_fd;
   logic     cc_flag;
   logic     sticky_exc;
   logic     sticky_ovf;
   logic     sticky_unf;
   logic     clr_sticky;
   reg_idx_t dbg_addr;
   word_t    dbg_data;

   modport slave (
      input  in_valid, in_op, in_fs, in_ft, in_fd,
      input  ext_we, ext_addr, ext_wdata,
      input  fpu_result, fpu_status_flag, fpu_exception, fpu_overflow_flag, fpu_underflow_flag,
      input  clr_sticky, dbg_addr,
      output in_ready, fpu_src1, fpu_src2, fpu_control,
      output wb_valid, wb_fd, cc_flag, sticky_exc, sticky_ovf, sticky_unf, dbg_data
   );

   modport master (
      output in_valid, in_op, in_fs, in_ft, in_fd,
      output ext_we, ext_addr, ext_wdata,
      output fpu_result, fpu_status_flag, fpu_exception, fpu_overflow_flag, fpu_underflow_flag,
      output clr_sticky, dbg_addr,
      input  in_ready, fpu_src1, fpu_src2, fpu_control,
      input  wb_valid, wb_fd, cc_flag, sticky_exc, sticky_ovf, sticky_unf, dbg_data
   );

endinterface

// File: rtl/fp_regfile.sv
// FP register file: two operand reads plus a debug read, FPU and ext write ports.
module fp_regfile
   import fpu_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  reg_idx_t ra1_i,
   input  reg_idx_t ra2_i,
   input  reg_idx_t dbg_addr_i,
   output word_t    rd1_o,
   output word_t    rd2_o,
   output word_t    dbg_data_o,
   input  logic     fpu_we_i,
   input  reg_idx_t fpu_waddr_i,
   input  word_t    fpu_wdata_i,
   input  logic     ext_we_i,
   input  reg_idx_t ext_waddr_i,
   input  word_t    ext_wdata_i
);

   word_t regs_q [NREGS];

   // FPU port checked first so a same-index collision keeps the FPU result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (fpu_we_i && (fpu_waddr_i == reg_idx_t'(i))) begin
               regs_q[i] <= fpu_wdata_i;
            end else if (ext_we_i && (ext_waddr_i == reg_idx_t'(i))) begin
               regs_q[i] <= ext_wdata_i;
            end
         end
      end
   end

   assign rd1_o      = regs_q[ra1_i];
   assign rd2_o      = regs_q[ra2_i];
   assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/fpu_issue_wb.sv
// Issue/writeback stage: one S1 register feeding a combinational FPU, result written back next edge.
module fpu_issue_wb
   import fpu_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   fpu_issue_wb_if.slave  bus
);

   logic     s1_valid_q, s1_valid_d;
   fpu_op_t  ctrl_q, ctrl_d;
   reg_idx_t fd_q, fd_d;
   word_t    src1_q, src1_d;
   word_t    src2_q, src2_d;
   logic     cc_q, cc_d;
   logic     exc_q, exc_d;
   logic     ovf_q, ovf_d;
   logic     unf_q, unf_d;

   word_t rf_rd1, rf_rd2;
   logic  accept, retire, fpu_we, illegal;

   assign accept  = bus.in_valid & ~bus.ext_we;
   assign retire  = s1_valid_q;
   assign fpu_we  = retire & is_wb_op(ctrl_q);
   assign illegal = retire & ~is_wb_op(ctrl_q) & ~is_cmp_op(ctrl_q);

   fp_regfile u_regfile (
      .clk         (clk),
      .rst_n       (rst_n),
      .ra1_i       (bus.in_fs),
      .ra2_i       (bus.in_ft),
      .dbg_addr_i  (bus.dbg_addr),
      .rd1_o       (rf_rd1),
      .rd2_o       (rf_rd2),
      .dbg_data_o  (bus.dbg_data),
      .fpu_we_i    (fpu_we),
      .fpu_waddr_i (fd_q),
      .fpu_wdata_i (bus.fpu_result),
      .ext_we_i    (bus.ext_we),
      .ext_waddr_i (bus.ext_addr),
      .ext_wdata_i (bus.ext_wdata)
   );

   always_comb begin
      s1_valid_d = accept;
      ctrl_d     = FPU_MOV1;
      fd_d       = fd_q;
      src1_d     = src1_q;
      src2_d     = src2_q;
      if (accept) begin
         ctrl_d = bus.in_op;
         fd_d   = bus.in_fd;
         // The retiring op's result is not yet in the file, so forward it per source.
         src1_d = (fpu_we && (fd_q == bus.in_fs)) ? bus.fpu_result : rf_rd1;
         src2_d = (fpu_we && (fd_q == bus.in_ft)) ? bus.fpu_result : rf_rd2;
      end

      cc_d  = (retire && is_cmp_op(ctrl_q)) ? bus.fpu_status_flag : cc_q;
      // Clear first, then OR in this edge's sets so a simultaneous set survives.
      exc_d = (exc_q & ~bus.clr_sticky) | illegal | (retire & bus.fpu_exception);
      ovf_d = (ovf_q & ~bus.clr_sticky) | (retire & bus.fpu_overflow_flag);
      unf_d = (unf_q & ~bus.clr_sticky) | (retire & bus.fpu_underflow_flag);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         ctrl_q     <= FPU_MOV1;
         fd_q       <= '0;
         src1_q     <= '0;
         src2_q     <= '0;
         cc_q       <= 1'b0;
         exc_q      <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         ctrl_q     <= ctrl_d;
         fd_q       <= fd_d;
         src1_q     <= src1_d;
         src2_q     <= src2_d;
         cc_q       <= cc_d;
         exc_q      <= exc_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign bus.in_ready    = ~bus.ext_we;
   assign bus.fpu_src1    = src1_q;
   assign bus.fpu_src2    = src2_q;
   assign bus.fpu_control = ctrl_q;
   assign bus.wb_valid    = s1_valid_q;
   assign bus.wb_fd       = fd_q;
   assign bus.cc_flag     = cc_q;
   assign bus.sticky_exc  = exc_q;
   assign bus.sticky_ovf  = ovf_q;
   assign bus.sticky_unf  = unf_q;

endmodule

// File: tb/tb_fpu_issue_wb.sv
// Directed scoreboard bench for fpu_issue_wb with a table-driven FPU stand-in.
module tb_fpu_issue_wb;
   import fpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic stub_ovf, stub_unf;

   always #5 clk = ~clk;

   fpu_issue_wb_if bus ();

   fpu_issue_wb dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Stand-in FPU: only the additions used by the vectors are tabulated.
   function automatic logic [31:0] stub_add(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] k;
      k = {a, b};
      case (k)
         64'h3F800000_40000000: return 32'h40400000;
         64'h40400000_3F800000: return 32'h40800000;
         64'h3F800000_3F800000: return 32'h40000000;
         64'h40000000_40000000: return 32'h40800000;
         default:               return 32'h7FC00000;
      endcase
   endfunction

   always_comb begin
      bus.fpu_result      = 32'h7FC00000;
      bus.fpu_status_flag = 1'b0;
      case (bus.fpu_control)
         FPU_MOV1, FPU_MOV2: bus.fpu_result = bus.fpu_src1;
         FPU_ADD:            bus.fpu_result = stub_add(bus.fpu_src1, bus.fpu_src2);
         FPU_SUB:            bus.fpu_result = 32'h7FC00000;
         FPU_EQ:             bus.fpu_status_flag = (bus.fpu_src1 == bus.fpu_src2);
         FPU_LT:             bus.fpu_status_flag = (bus.fpu_src1 <  bus.fpu_src2);
         FPU_LE:             bus.fpu_status_flag = (bus.fpu_src1 <= bus.fpu_src2);
         FPU_GE:             bus.fpu_status_flag = (bus.fpu_src1 >= bus.fpu_src2);
         FPU_GT:             bus.fpu_status_flag = (bus.fpu_src1 >  bus.fpu_src2);
         default:            bus.fpu_result = 32'hDEADBEEF;
      endcase
   end

   assign bus.fpu_exception      = 1'b0;
   assign bus.fpu_overflow_flag  = stub_ovf;
   assign bus.fpu_underflow_flag = stub_unf;

   typedef struct packed {
      logic [4:0]  fd;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [3:0]  op;
   } exp_t;

   exp_t exp_q [$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every retirement must match the oldest outstanding issue.
   always @(negedge clk) begin
      if (rst_n && bus.wb_valid) begin
         if (exp_q.size() == 0) begin
            chk("wb_unexpected", 32'(bus.wb_valid), 32'h0);
         end else begin
            mon_e = exp_q.pop_front();
            $display("wb  fd=%0d op=%h src1=%h src2=%h result=%h",
                     bus.wb_fd, bus.fpu_control, bus.fpu_src1, bus.fpu_src2, bus.fpu_result);
            chk("wb_fd", 32'(bus.wb_fd), 32'(mon_e.fd));
            chk("wb_src1", bus.fpu_src1, mon_e.s1);
            chk("wb_src2", bus.fpu_src2, mon_e.s2);
            chk("wb_ctrl", 32'(bus.fpu_control), 32'(mon_e.op));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [4:0] fs, input logic [4:0] ft,
                        input logic [4:0] fd, input logic [31:0] e1, input logic [31:0] e2,
                        input bit track);
      exp_t e;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_fs    = fs;
      bus.in_ft    = ft;
      bus.in_fd    = fd;
      if (track) begin
         e.fd = fd; e.s1 = e1; e.s2 = e2; e.op = op;
         exp_q.push_back(e);
      end
      $display("iss op=%h fs=%0d ft=%0d fd=%0d", op, fs, ft, fd);
      @(negedge clk);
      chk("in_ready_issue", 32'(bus.in_ready), 32'h1);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic ext_write(input logic [4:0] addr, input logic [31:0] data);
      bus.ext_we    = 1'b1;
      bus.ext_addr  = addr;
      bus.ext_wdata = data;
      $display("ext f%0d <= %h", addr, data);
      @(negedge clk);
      chk("in_ready_ext", 32'(bus.in_ready), 32'h0);
      step();
      bus.ext_we = 1'b0;
   endtask

   task automatic check_reg(input logic [4:0] addr, input logic [31:0] exp, input string name);
      bus.dbg_addr = addr;
      #1;
      chk(name, bus.dbg_data, exp);
   endtask

   initial begin
      rst_n          = 1'b0;
      stub_ovf       = 1'b0;
      stub_unf       = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_op      = '0;
      bus.in_fs      = '0;
      bus.in_ft      = '0;
      bus.in_fd      = '0;
      bus.ext_we     = 1'b0;
      bus.ext_addr   = '0;
      bus.ext_wdata  = '0;
      bus.clr_sticky = 1'b0;
      bus.dbg_addr   = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb_valid", 32'(bus.wb_valid), 32'h0);
      chk("rst_ctrl", 32'(bus.fpu_control), 32'h0);
      chk("rst_src1", bus.fpu_src1, 32'h0);
      chk("rst_src2", bus.fpu_src2, 32'h0);
      chk("rst_cc", 32'(bus.cc_flag), 32'h0);
      chk("rst_exc", 32'(bus.sticky_exc), 32'h0);
      chk("rst_ovf", 32'(bus.sticky_ovf), 32'h0);
      chk("rst_unf", 32'(bus.sticky_unf), 32'h0);
      check_reg(5'd0, 32'h0, "rst_f0");
      check_reg(5'd31, 32'h0, "rst_f31");
      rst_n = 1'b1;
      step();

      ext_write(5'd1, 32'h3F800000);
      ext_write(5'd2, 32'h40000000);
      check_reg(5'd1, 32'h3F800000, "ext_f1");
      check_reg(5'd2, 32'h40000000, "ext_f2");

      // Basic add with two-edge latency
      issue(FPU_ADD, 5'd1, 5'd2, 5'd3, 32'h3F800000, 32'h40000000, 1'b1);
      check_reg(5'd3, 32'h0, "add_f3_early");
      step();
      check_reg(5'd3, 32'h40400000, "add_f3");

      // RAW bypass on fs
      ext_write(5'd3, 32'h0);
      issue(FPU_ADD, 5'd1, 5'd2, 5'd3, 32'h3F800000, 32'h40000000, 1'b1);
      issue(FPU_ADD, 5'd3, 5'd1, 5'd4, 32'h40400000, 32'h3F800000, 1'b1);
      step();
      check_reg(5'd3, 32'h40400000, "raw_f3");
      check_reg(5'd4, 32'h40800000, "raw_f4");

      // fs == ft == fd bypass
      issue(FPU_ADD, 5'd1, 5'd1, 5'd6, 32'h3F800000, 32'h3F800000, 1'b1);
      issue(FPU_ADD, 5'd6, 5'd6, 5'd6, 32'h40000000, 32'h40000000, 1'b1);
      step();
      check_reg(5'd6, 32'h40800000, "byp_f6");

      // Compare
      issue(FPU_LT, 5'd1, 5'd2, 5'd1, 32'h3F800000, 32'h40000000, 1'b1);
      step();
      chk("cmp_lt_cc", 32'(bus.cc_flag), 32'h1);
      check_reg(5'd1, 32'h3F800000, "cmp_f1");
      check_reg(5'd2, 32'h40000000, "cmp_f2");
      issue(FPU_GT, 5'd1, 5'd2, 5'd1, 32'h3F800000, 32'h40000000, 1'b1);
      step();
      chk("cmp_gt_cc", 32'(bus.cc_flag), 32'h0);
      check_reg(5'd1, 32'h3F800000, "cmp_gt_f1");

      // Illegal op: no write, cc held
      issue(FPU_LT, 5'd1, 5'd2, 5'd9, 32'h3F800000, 32'h40000000, 1'b1);
      step();
      issue(4'hF, 5'd1, 5'd2, 5'd5, 32'h3F800000, 32'h40000000, 1'b1);
      step();
      check_reg(5'd5, 32'h0, "ill_f5");
      chk("ill_exc", 32'(bus.sticky_exc), 32'h1);
      chk("ill_cc_held", 32'(bus.cc_flag), 32'h1);
      bus.clr_sticky = 1'b1;
      step();
      bus.clr_sticky = 1'b0;
      chk("clr_exc", 32'(bus.sticky_exc), 32'h0);
      issue(4'hF, 5'd1, 5'd2, 5'd5, 32'h3F800000, 32'h40000000, 1'b1);
      bus.clr_sticky = 1'b1;
      step();
      bus.clr_sticky = 1'b0;
      chk("clr_vs_set_exc", 32'(bus.sticky_exc), 32'h1);

      // Overflow / underflow accumulate only on retire
      issue(FPU_ADD, 5'd1, 5'd2, 5'd7, 32'h3F800000, 32'h40000000, 1'b1);
      stub_ovf = 1'b1;
      step();
      stub_ovf = 1'b0;
      chk("ovf_set", 32'(bus.sticky_ovf), 32'h1);
      chk("unf_clear", 32'(bus.sticky_unf), 32'h0);
      stub_unf = 1'b1;
      step();
      stub_unf = 1'b0;
      chk("unf_idle", 32'(bus.sticky_unf), 32'h0);
      bus.clr_sticky = 1'b1;
      step();
      bus.clr_sticky = 1'b0;
      chk("clr_ovf", 32'(bus.sticky_ovf), 32'h0);

      // Write collision: FPU beats ext on the same index
      ext_write(5'd3, 32'h0);
      issue(FPU_ADD, 5'd1, 5'd2, 5'd3, 32'h3F800000, 32'h40000000, 1'b1);
      ext_write(5'd3, 32'h12345678);
      check_reg(5'd3, 32'h40400000, "coll_f3");

      // Reset mid-op
      issue(FPU_LT, 5'd1, 5'd2, 5'd9, 32'h3F800000, 32'h40000000, 1'b1);
      step();
      issue(4'hF, 5'd1, 5'd2, 5'd9, 32'h3F800000, 32'h40000000, 1'b1);
      step();
      chk("pre_rst_cc", 32'(bus.cc_flag), 32'h1);
      chk("pre_rst_exc", 32'(bus.sticky_exc), 32'h1);
      issue(FPU_ADD, 5'd1, 5'd2, 5'd8, 32'h3F800000, 32'h40000000, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_wb_valid", 32'(bus.wb_valid), 32'h0);
      chk("mid_rst_ctrl", 32'(bus.fpu_control), 32'h0);
      chk("mid_rst_src1", bus.fpu_src1, 32'h0);
      chk("mid_rst_cc", 32'(bus.cc_flag), 32'h0);
      chk("mid_rst_exc", 32'(bus.sticky_exc), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      step();
      check_reg(5'd8, 32'h0, "mid_rst_f8");
      check_reg(5'd1, 32'h0, "mid_rst_f1");

      chk("sb_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
